srt_otf_quotient: RTL and testbench

Sequential on-the-fly (OTF) quotient converter for the radix-4 SRT divider. It consumes the signed quotient digit stream, one digit per iteration, in the same 3-bit signed-digit format that drives `next_remainder_gen`. It builds the conventional binary quotient incrementally, with no carry-propagate adder, by maintaining the Q and QM (Q − 1 ulp) registers. After the last digit, it applies the final sign correction from the last partial remainder and presents the finished quotient to the normalisation/rounding stage.

---
 rtl/srt_otf_quotient.sv | 128 ++++++++++++
 tb/tb_srt_otf_quotient.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt_otf_quotient.sv
// ---------------------------------------------------------------------------
// srt_otf_quotient
// On-the-fly quotient converter for the radix-4 SRT divider. Accepts one
// signed-magnitude quotient digit per iteration and keeps two registers, Q and
// QM = Q - 1 ulp, so that every digit (positive, zero or negative) becomes a
// 2-bit append without any carry-propagate adder. After the last digit, the
// sign of the final partial remainder selects Q or QM as the finished quotient.
// ---------------------------------------------------------------------------
module srt_otf_quotient #(
  parameter int NDIGITS = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   digit_valid,
  input  logic [2:0]             digit,
  input  logic                   rem_valid,
  input  logic                   rem_neg,
  output logic                   busy,
  output logic                   q_valid,
  output logic [2*NDIGITS-1:0]   quotient,
  output logic                   digit_err
);

  localparam int W  = 2 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CORR  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_qm;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_q_valid;
  logic [W-1:0]    r_quotient;
  logic            r_digit_err;

  logic [1:0]      w_mag;
  logic            w_bad;
  logic            w_zero;
  logic            w_neg;
  logic [W-1:0]    w_q_next;
  logic [W-1:0]    w_qm_next;

  // Digit decode and next Q/QM: each case is a pure 2-bit append to Q or QM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_mag     = digit[1:0];
    w_bad     = &w_mag;                       // magnitude 3 is illegal, use 0
    w_zero    = (w_mag == 2'd0) || w_bad;     // also covers negative zero
    w_neg     = digit[2] && !w_zero;
    w_q_next  = W'({r_q,  2'b00});
    w_qm_next = W'({r_qm, 2'b11});
    if (w_neg) begin
      // -m: Q takes QM with low digit 4-m, QM takes QM with low digit 3-m.
      w_q_next  = W'({r_qm, 2'(~w_mag + 2'd1)});
      w_qm_next = W'({r_qm, ~w_mag});
    end else if (!w_zero) begin
      w_q_next  = W'({r_q, w_mag});
      w_qm_next = W'({r_q, 2'(w_mag - 2'd1)});
    end
  end

  // Control FSM plus Q/QM accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_qm        <= '1;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_q_valid   <= 1'b0;
      r_quotient  <= '0;
      r_digit_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      r_q_valid   <= 1'b0;
      r_digit_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= '0;
            r_qm    <= '1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (digit_valid) begin
            r_q         <= w_q_next;
            r_qm        <= w_qm_next;
            r_digit_err <= w_bad;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == CW'(NDIGITS - 1)) begin
              r_state <= S_CORR;
            end
          end
        end
        S_CORR: begin
          if (rem_valid) begin
            r_quotient <= rem_neg ? r_qm : r_q;
            r_q_valid  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign q_valid   = r_q_valid;
  assign quotient  = r_quotient;
  assign digit_err = r_digit_err;

endmodule

// File: tb/tb_srt_otf_quotient.sv
// ---------------------------------------------------------------------------
// tb_srt_otf_quotient
// Self-checking bench for srt_otf_quotient with NDIGITS=4. Expected quotients
// come from plain integer arithmetic: sum of digit values times powers of 4,
// minus one when the final remainder is negative, taken modulo 2^8.
// ---------------------------------------------------------------------------
module tb_srt_otf_quotient;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         digit_valid;
  logic [2:0]   digit;
  logic         rem_valid;
  logic         rem_neg;
  logic         busy;
  logic         q_valid;
  logic [W-1:0] quotient;
  logic         digit_err;

  int checks;
  int errors;

  srt_otf_quotient #(.NDIGITS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit_valid (digit_valid),
    .digit       (digit),
    .rem_valid   (rem_valid),
    .rem_neg     (rem_neg),
    .busy        (busy),
    .q_valid     (q_valid),
    .quotient    (quotient),
    .digit_err   (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient = sum(d_i * 4^(N-1-i)) - rem_neg, mod 2^W.
  function automatic logic [W-1:0] ref_q(input logic [2:0] ds [N], input bit neg);
    int v;
    int m;
    v = 0;
    for (int i = 0; i < N; i++) begin
      m = int'(ds[i][1:0]);
      if (m == 3) m = 0;
      v = v * 4 + (ds[i][2] ? -m : m);
    end
    v = v - int'(neg);
    return v[W-1:0];
  endfunction

  function automatic int ref_err(input logic [2:0] ds [N]);
    int e;
    e = 0;
    for (int i = 0; i < N; i++) if (ds[i][1:0] == 2'b11) e++;
    return e;
  endfunction

  // Drives one complete division. noise adds start/rem_valid during ACCUM
  // gaps, start/digit_valid in CORR, and start alongside rem_valid.
  task automatic do_div(input logic [2:0] ds [N], input int gap, input bit neg,
                        input bit noise, output logic [W-1:0] q, output bit qv_ok,
                        output int err_cnt, output int busy_bad);
    int qv_cnt;
    qv_cnt   = 0;
    err_cnt  = 0;
    busy_bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    if (!busy) busy_bad++;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          rem_valid = 1'b1;
          rem_neg   = 1'b1;
          start     = 1'b1;
        end
        step();
        rem_valid = 1'b0;
        rem_neg   = 1'b0;
        start     = 1'b0;
        if (!busy) busy_bad++;
        err_cnt += int'(digit_err);
        qv_cnt  += int'(q_valid);
      end
      digit_valid = 1'b1;
      digit       = ds[i];
      step();
      digit_valid = 1'b0;
      digit       = 3'b000;
      if (!busy) busy_bad++;
      err_cnt += int'(digit_err);
      qv_cnt  += int'(q_valid);
    end
    if (noise) begin
      digit_valid = 1'b1;
      digit       = 3'b011;
      start       = 1'b1;
      step();
      digit_valid = 1'b0;
      digit       = 3'b000;
      start       = 1'b0;
      if (!busy) busy_bad++;
      err_cnt += int'(digit_err);
      qv_cnt  += int'(q_valid);
    end
    rem_valid = 1'b1;
    rem_neg   = neg;
    start     = noise;
    step();
    rem_valid = 1'b0;
    rem_neg   = 1'b0;
    start     = 1'b0;
    qv_ok     = q_valid && !busy && (qv_cnt == 0);
    q         = quotient;
    err_cnt  += int'(digit_err);
    step();
    if (q_valid || busy) qv_ok = 1'b0;
    err_cnt += int'(digit_err);
  endtask

  task automatic test_reset();
    int qv_seen;
    qv_seen = 0;
    repeat (5) begin
      step();
      qv_seen += int'(q_valid) + int'(busy) + int'(digit_err);
    end
    checks++;
    if (busy !== 1'b0 || q_valid !== 1'b0 || quotient !== 8'h00 || qv_seen != 0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b q_valid=%b quotient=%h activity=%0d, required 0 0 00 0",
               busy, q_valid, quotient, qv_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ds [N];
    logic [W-1:0] q;
    bit           ok;
    int           e;
    int           bb;
    ds = '{3'b001, 3'b010, 3'b000, 3'b001};
    for (int r = 0; r < 2; r++) begin
      do_div(ds, 0, r[0], 1'b0, q, ok, e, bb);
      checks++;
      if (q !== ref_q(ds, r[0])) begin
        errors++;
        $display("FAIL b2b_quotient neg=%0d: got %h required %h", r, q, ref_q(ds, r[0]));
      end
      checks++;
      if (!ok || e != 0 || bb != 0) begin
        errors++;
        $display("FAIL b2b_handshake neg=%0d: qv_ok=%0d errs=%0d busy_bad=%0d, required 1 0 0",
                 r, ok, e, bb);
      end
    end
    checks++;
    if (quotient !== 8'h60) begin
      errors++;
      $display("FAIL b2b_hold: got %h required 60", quotient);
    end
  endtask

  task automatic test_gaps();
    logic [2:0]   ds [N];
    logic [W-1:0] q;
    bit           ok;
    int           e;
    int           bb;
    ds = '{3'b010, 3'b101, 3'b110, 3'b001};
    do_div(ds, 2, 1'b0, 1'b0, q, ok, e, bb);
    checks++;
    if (q !== 8'h69) begin
      errors++;
      $display("FAIL gaps_quotient: got %h required 69", q);
    end
    checks++;
    if (!ok || bb != 0) begin
      errors++;
      $display("FAIL gaps_busy: qv_ok=%0d busy_bad=%0d, required 1 0", ok, bb);
    end
  endtask

  task automatic test_neg_zero();
    logic [2:0]   ds [N];
    logic [W-1:0] q;
    bit           ok;
    int           e;
    int           bb;
    ds = '{3'b001, 3'b110, 3'b100, 3'b000};
    do_div(ds, 1, 1'b1, 1'b0, q, ok, e, bb);
    checks++;
    if (q !== 8'h1F || !ok) begin
      errors++;
      $display("FAIL neg_zero: got %h qv_ok=%0d required 1f 1", q, ok);
    end
  endtask

  task automatic test_digit_err_and_ignore();
    logic [2:0]   ds [N];
    logic [W-1:0] q;
    bit           ok;
    int           e;
    int           bb;
    ds = '{3'b001, 3'b011, 3'b000, 3'b000};
    do_div(ds, 1, 1'b0, 1'b1, q, ok, e, bb);
    checks++;
    if (e != 1) begin
      errors++;
      $display("FAIL digit_err_count: got %0d required 1", e);
    end
    checks++;
    if (q !== 8'h40) begin
      errors++;
      $display("FAIL ignore_quotient: got %h required 40", q);
    end
    checks++;
    if (!ok || bb != 0) begin
      errors++;
      $display("FAIL ignore_handshake: qv_ok=%0d busy_bad=%0d required 1 0", ok, bb);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0]   ds [N];
    logic [W-1:0] q;
    bit           ok;
    int           e;
    int           bb;
    int           stray;
    stray = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      digit_valid = 1'b1;
      digit       = 3'b010;
      step();
      digit_valid = 1'b0;
      stray += int'(q_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || quotient !== 8'h00 || q_valid !== 1'b0 || digit_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b quotient=%h q_valid=%b digit_err=%b required 0 00 0 0",
               busy, quotient, q_valid, digit_err);
    end
    rem_valid = 1'b1;
    step();
    rem_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (2) begin
      step();
      stray += int'(q_valid) + int'(busy);
    end
    ds = '{3'b001, 3'b001, 3'b001, 3'b001};
    do_div(ds, 0, 1'b0, 1'b0, q, ok, e, bb);
    checks++;
    if (q !== 8'h55 || !ok || stray != 0) begin
      errors++;
      $display("FAIL reset_then_run: got %h qv_ok=%0d stray=%0d required 55 1 0", q, ok, stray);
    end
  endtask

  task automatic test_random();
    logic [2:0]   ds [N];
    logic [W-1:0] q;
    bit           ok;
    bit           neg;
    int           e;
    int           bb;
    int           gap;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) ds[i] = 3'($urandom_range(0, 7));
      gap = int'($urandom_range(0, 2));
      neg = 1'($urandom_range(0, 1));
      do_div(ds, gap, neg, 1'($urandom_range(0, 1)), q, ok, e, bb);
      checks++;
      if (q !== ref_q(ds, neg)) begin
        errors++;
        $display("FAIL rand_quotient[%0d]: got %h required %h", t, q, ref_q(ds, neg));
      end
      checks++;
      if (e != ref_err(ds) || !ok || bb != 0) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: errs=%0d qv_ok=%0d busy_bad=%0d required %0d 1 0",
                 t, e, ok, bb, ref_err(ds));
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    digit_valid = 1'b0;
    digit       = 3'b000;
    rem_valid   = 1'b0;
    rem_neg     = 1'b0;
    #12 rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_neg_zero();
    test_digit_err_and_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
